// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and round helper functions.
// Shared by sha256_core and sha256_round.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUNDS,
    DONE
  } state_e;

  // Word 7 is a/H0, word 0 is h/H7, so the vector matches digest layout.
  typedef logic [7:0][31:0] hvec_t;

  localparam hvec_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hvec_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x,
                                      input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x,
                                     input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x,
                                      input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Working state packed as {a,b,c,d,e,f,g,h}.
module sha256_round
  import sha256_pkg::*;
(
  input  hvec_t       s_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output hvec_t       s_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  always_comb begin
    {a, b, c, d, e, f, g, h} = s_i;
    t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
    t2 = bsig0(a) + maj(a, b, c);
    s_o = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

endmodule

// File: rtl/sha256_core.sv
// Single-block SHA-256 engine, ROUNDS_PER_CYCLE in {1,2,4}.
// SHA256_CORE_SHA224_MODE_EN adds a mode port for SHA-224.
module sha256_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
`ifdef SHA256_CORE_SHA224_MODE_EN
  input  logic         mode,
`endif
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] STEP = 6'(R);
  localparam logic [5:0] LAST = 6'(64 - R);

  state_e      state_q;
  logic [5:0]  t_q;
  logic [31:0] w_q [16];
  hvec_t       work_q;
  hvec_t       h_q;
  logic [255:0] digest_q;
  logic        ready_q;
  logic        valid_q;
  logic        fin_q;
  logic        init_q;
  logic        mode_q;

  logic [31:0] ext [16+R];
  hvec_t       st [R+1];
  hvec_t       iv_load;
  hvec_t       iv_run;
  hvec_t       base;
  hvec_t       sum_d;
  logic [255:0] digest_d;
  logic        mode_d;

  // Window extended by R freshly computed schedule words.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = w_q[i];
    end
    for (int j = 0; j < R; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j]
                + ssig0(ext[1+j]) + ext[j];
    end
  end

  assign st[0] = work_q;

  for (genvar g = 0; g < R; g++) begin : g_rnd
    logic [5:0] kidx;
    assign kidx = t_q + 6'(g);
    sha256_round u_rnd (
      .s_i (st[g]),
      .k_i (K[kidx]),
      .w_i (ext[g]),
      .s_o (st[g+1])
    );
  end

`ifdef SHA256_CORE_SHA224_MODE_EN
  assign mode_d  = mode;
  assign iv_load = mode ? IV224 : IV256;
  assign iv_run  = mode_q ? IV224 : IV256;
`else
  assign mode_d  = 1'b0;
  assign iv_load = IV256;
  assign iv_run  = IV256;
`endif

  always_comb begin
    base = init_q ? iv_run : h_q;
    for (int i = 0; i < 8; i++) begin
      sum_d[i] = base[i] + work_q[i];
    end
    digest_d = sum_d;
    if (mode_q) begin
      digest_d[31:0] = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      work_q   <= '0;
      h_q      <= '0;
      digest_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      fin_q    <= 1'b0;
      init_q   <= 1'b0;
      mode_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fin_q) begin
            // Result published one edge after the H update.
            fin_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
          end else if (ready_q && (init || next)) begin
            for (int i = 0; i < 16; i++) begin
              w_q[i] <= block[511-32*i -: 32];
            end
            work_q  <= init ? iv_load : h_q;
            init_q  <= init;
            if (init) begin
              mode_q <= mode_d;
            end
            t_q     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            state_q <= ROUNDS;
          end
        end
        ROUNDS: begin
          work_q <= st[R];
          for (int i = 0; i < 16; i++) begin
            w_q[i] <= ext[i+R];
          end
          t_q <= t_q + STEP;
          if (t_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          h_q      <= sum_d;
          digest_q <= digest_d;
          fin_q    <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign digest       = digest_q;
  assign digest_valid = valid_q;

endmodule

// File: tb/tb_sha256_core.sv
// Scoreboard bench for sha256_core: FIPS vectors, latency,
// busy-command rejection and mid-operation reset.
module tb_sha256_core;

  localparam int RPC = 2;
  localparam int LAT = 64 / RPC + 2;

  typedef struct {
    string        tag;
    logic [255:0] dig;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         init;
  logic         next;
  logic [511:0] block;
  logic         ready;
  logic [255:0] digest;
  logic         digest_valid;
`ifdef SHA256_CORE_SHA224_MODE_EN
  logic         mode;
`endif

  exp_t sb [$];
  int   n_chk;
  int   n_fail;

  sha256_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .next         (next),
    .block        (block),
`ifdef SHA256_CORE_SHA224_MODE_EN
    .mode         (mode),
`endif
    .ready        (ready),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic is_init,
                     input logic [511:0] blk,
                     input logic [255:0] exp,
                     input string tag,
                     input int busy_at);
    logic [255:0] prev;
    exp_t         e;
    int           n;
    bit           done;
    @(negedge clk);
    prev  = digest;
    init  = is_init;
    next  = !is_init;
    block = blk;
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
    init  = 1'b0;
    next  = 1'b0;
    block = {16{$urandom}};
    check({tag, "_busy"}, 256'(ready), 256'(0));
    check({tag, "_hold"}, digest, prev);
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (digest_valid) begin
        done = 1'b1;
      end else if (n == busy_at) begin
        init = 1'b1;
        next = 1'b1;
      end else begin
        init = 1'b0;
        next = 1'b0;
      end
    end
    init = 1'b0;
    next = 1'b0;
    check({tag, "_lat"}, 256'(n), 256'(LAT));
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 256'(0), 256'(1));
    end else begin
      e = sb.pop_front();
      check(e.tag, digest, e.dig);
    end
    check({tag, "_rdy"}, 256'(ready), 256'(1));
  endtask

  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_ABC =
    {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B_TWO2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_MID =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_224 =
    256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    init   = 1'b0;
    next   = 1'b0;
    block  = '0;
`ifdef SHA256_CORE_SHA224_MODE_EN
    mode   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 256'(ready), 256'(1));
    check("rst_valid", 256'(digest_valid), 256'(0));
    check("rst_digest", digest, 256'(0));

    run(1'b1, B_EMPTY, D_EMPTY, "empty", 0);
    run(1'b1, B_ABC, D_ABC, "abc", 0);
    run(1'b1, B_TWO1, D_MID, "two_mid", 0);
    run(1'b0, B_TWO2, D_TWO, "two_fin", 0);
    run(1'b1, B_ABC, D_ABC, "abc_busy", 5);

    // Abort mid-operation.
    @(negedge clk);
    init  = 1'b1;
    block = B_EMPTY;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 256'(ready), 256'(1));
    check("abort_valid", 256'(digest_valid), 256'(0));
    check("abort_digest", digest, 256'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(1'b1, B_ABC, D_ABC, "abc_after_abort", 0);

`ifdef SHA256_CORE_SHA224_MODE_EN
    mode = 1'b1;
    run(1'b1, B_ABC, D_224, "sha224_abc", 0);
    mode = 1'b0;
`endif

    check("sb_drained", 256'(sb.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
